// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared encodings and widths for the SRAM-like port arbiter
package sram_like_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_HOLD = 1'b1
    } lock_state_t;

    // Request bundle width: wr + size + wstrb + addr + wdata
    function automatic int req_bus_w(input int aw, input int dw);
        return 1 + 2 + 4 + aw + dw;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// rtl/sram_like_arbiter_owner_fifo.sv - in-order 1-bit owner FIFO for outstanding transactions
module owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic       push_own,
    input  logic       pop,
    output logic       head,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 3'd0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap explicitly so non-power-of-two depths stay correct
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_own;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 3'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 3'd1;
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - fixed-priority inst/data arbiter onto one SRAM-like port with in-order response routing
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [3:0]    inst_wstrb,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [3:0]    data_wstrb,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,
    output logic          s_req,
    output logic          s_wr,
    output logic [1:0]    s_size,
    output logic [3:0]    s_wstrb,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_addr_ok,
    input  logic          s_data_ok,
    input  logic [DW-1:0] s_rdata,
    output logic [2:0]    outst_cnt,
    output logic          err_unexp_rsp
);
    localparam int REQ_W = req_bus_w(AW, DW);

    lock_state_t      state;
    logic             hold_own;
    logic             gnt_vld;
    logic             gnt_own;
    logic             accept;
    logic             pop;
    logic             head;
    logic             full;
    logic             empty;
    logic [REQ_W-1:0] inst_bus;
    logic [REQ_W-1:0] data_bus;
    logic [REQ_W-1:0] s_bus;

    assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

    // A held grant never moves to data, even if data_req rises meanwhile
    always_comb begin
        gnt_vld = 1'b0;
        gnt_own = OWN_INST;
        if (state == LK_IDLE) begin
            if (!full) begin
                if (data_req) begin
                    gnt_vld = 1'b1;
                    gnt_own = OWN_DATA;
                end else if (inst_req) begin
                    gnt_vld = 1'b1;
                    gnt_own = OWN_INST;
                end
            end
        end else begin
            gnt_own = hold_own;
            gnt_vld = ~full & ((hold_own == OWN_DATA) ? data_req : inst_req);
        end
    end

    assign s_bus  = gnt_vld ? ((gnt_own == OWN_DATA) ? data_bus : inst_bus) : '0;
    assign {s_wr, s_size, s_wstrb, s_addr, s_wdata} = s_bus;
    assign s_req  = gnt_vld;
    assign accept = gnt_vld & s_addr_ok;

    assign data_addr_ok = accept & (gnt_own == OWN_DATA);
    assign inst_addr_ok = accept & (gnt_own == OWN_INST);

    assign pop          = s_data_ok & ~empty;
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_data_ok = pop & (head == OWN_INST);
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;

    owner_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_own(gnt_own),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (outst_cnt)
    );

    // Losing the grantee's req while held is a protocol violation; fall back to IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= LK_IDLE;
            hold_own <= OWN_INST;
        end else begin
            case (state)
                LK_IDLE: begin
                    if (gnt_vld && !s_addr_ok) begin
                        state    <= LK_HOLD;
                        hold_own <= gnt_own;
                    end
                end
                LK_HOLD: begin
                    if (accept || !gnt_vld) begin
                        state <= LK_IDLE;
                    end
                end
                default: state <= LK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_unexp_rsp <= 1'b0;
        end else if (s_data_ok && empty) begin
            err_unexp_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic [2:0]  outst_cnt;
    logic        err_unexp_rsp;

    int n_checks = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTST(2), .AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(outst_cnt), .err_unexp_rsp(err_unexp_rsp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'hBFC0_0000; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0000_1000; data_wdata = 32'h0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 32'h0;
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        #12;
        chk("rst_cnt", 32'(outst_cnt), 0);
        chk("rst_sreq", 32'(s_req), 0);
        chk("rst_err", 32'(err_unexp_rsp), 0);
        chk("rst_saddr_gated", s_addr, 32'h0);
        @(negedge clk); resetn = 1;

        // Priority: both request, data wins, inst follows next cycle
        @(negedge clk);
        inst_req = 1; data_req = 1; s_addr_ok = 1;
        #1;
        chk("prio_saddr", s_addr, 32'h0000_1000);
        chk("prio_data_aok", 32'(data_addr_ok), 1);
        chk("prio_inst_aok", 32'(inst_addr_ok), 0);
        @(negedge clk);
        data_req = 0;
        #1;
        chk("prio2_saddr", s_addr, 32'hBFC0_0000);
        chk("prio2_inst_aok", 32'(inst_addr_ok), 1);
        chk("prio2_cnt", 32'(outst_cnt), 1);

        // Full: gate closed, pop in same cycle does not reopen it
        @(negedge clk);
        inst_addr = 32'hBFC0_0004; s_data_ok = 1; s_rdata = 32'hAAAA_0001;
        #1;
        chk("full_cnt", 32'(outst_cnt), 2);
        chk("full_sreq", 32'(s_req), 0);
        chk("full_inst_aok", 32'(inst_addr_ok), 0);
        chk("full_pop_data_dok", 32'(data_data_ok), 1);
        chk("full_pop_inst_dok", 32'(inst_data_ok), 0);
        chk("full_pop_rdata", data_rdata, 32'hAAAA_0001);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("reopen_sreq", 32'(s_req), 1);
        chk("reopen_inst_aok", 32'(inst_addr_ok), 1);
        chk("reopen_cnt", 32'(outst_cnt), 1);
        @(negedge clk);
        inst_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h1111_1111;
        #1;
        chk("drain1_inst_dok", 32'(inst_data_ok), 1);
        chk("drain1_data_dok", 32'(data_data_ok), 0);
        @(negedge clk);
        s_rdata = 32'h2222_2222;
        #1;
        chk("drain2_inst_dok", 32'(inst_data_ok), 1);
        chk("drain2_cnt", 32'(outst_cnt), 1);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("drained_cnt", 32'(outst_cnt), 0);

        // In-order routing: inst then data accepted, responses return in that order
        inst_addr = 32'hBFC0_0000;
        inst_req = 1; s_addr_ok = 1;
        #1;
        chk("ord_inst_aok", 32'(inst_addr_ok), 1);
        @(negedge clk);
        inst_req = 0; data_req = 1;
        #1;
        chk("ord_data_aok", 32'(data_addr_ok), 1);
        @(negedge clk);
        data_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h1111_1111;
        #1;
        chk("ord_cnt2", 32'(outst_cnt), 2);
        chk("ord_r1_inst_dok", 32'(inst_data_ok), 1);
        chk("ord_r1_data_dok", 32'(data_data_ok), 0);
        chk("ord_r1_rdata", inst_rdata, 32'h1111_1111);
        @(negedge clk);
        s_rdata = 32'h2222_2222;
        #1;
        chk("ord_cnt1", 32'(outst_cnt), 1);
        chk("ord_r2_data_dok", 32'(data_data_ok), 1);
        chk("ord_r2_inst_dok", 32'(inst_data_ok), 0);
        chk("ord_r2_rdata", data_rdata, 32'h2222_2222);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("ord_cnt0", 32'(outst_cnt), 0);

        // Hold: stalled inst keeps the grant against a later data_req
        inst_req = 1;
        #1;
        chk("hold0_saddr", s_addr, 32'hBFC0_0000);
        @(negedge clk);
        data_req = 1; data_wr = 1; data_wstrb = 4'hF;
        #1;
        chk("hold1_saddr", s_addr, 32'hBFC0_0000);
        chk("hold1_data_aok", 32'(data_addr_ok), 0);
        @(negedge clk);
        #1;
        chk("hold2_saddr", s_addr, 32'hBFC0_0000);
        @(negedge clk);
        s_addr_ok = 1;
        #1;
        chk("hold_rel_inst_aok", 32'(inst_addr_ok), 1);
        chk("hold_rel_data_aok", 32'(data_addr_ok), 0);
        @(negedge clk);
        inst_req = 0;
        #1;
        chk("after_hold_saddr", s_addr, 32'h0000_1000);
        chk("after_hold_data_aok", 32'(data_addr_ok), 1);
        chk("after_hold_swr", 32'(s_wr), 1);
        chk("after_hold_swstrb", 32'(s_wstrb), 32'hF);

        // Reset while holding with outstanding traffic
        @(negedge clk);
        data_req = 0; data_wr = 0; data_wstrb = 4'h0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        chk("pre_rst_inst_dok", 32'(inst_data_ok), 1);
        @(negedge clk);
        s_data_ok = 0; inst_req = 1;
        @(negedge clk);
        data_req = 1;
        #1;
        chk("pre_rst_hold_saddr", s_addr, 32'hBFC0_0000);
        chk("pre_rst_cnt", 32'(outst_cnt), 1);
        inst_req = 0; data_req = 0;
        #1 resetn = 0;
        #1;
        chk("mid_rst_cnt", 32'(outst_cnt), 0);
        chk("mid_rst_sreq", 32'(s_req), 0);
        @(negedge clk);
        resetn = 1; inst_req = 1; data_req = 1; s_addr_ok = 1;
        #1;
        chk("post_rst_saddr", s_addr, 32'h0000_1000);
        chk("post_rst_data_aok", 32'(data_addr_ok), 1);
        @(negedge clk);
        inst_req = 0; data_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        chk("post_rst_data_dok", 32'(data_data_ok), 1);

        // Unexpected response on empty FIFO
        @(negedge clk);
        #1;
        chk("unexp_inst_dok", 32'(inst_data_ok), 0);
        chk("unexp_data_dok", 32'(data_data_ok), 0);
        @(negedge clk);
        s_data_ok = 0;
        #1;
        chk("unexp_err_set", 32'(err_unexp_rsp), 1);
        @(negedge clk);
        #1;
        chk("unexp_err_sticky", 32'(err_unexp_rsp), 1);
        #1 resetn = 0;
        #1;
        chk("unexp_err_clr", 32'(err_unexp_rsp), 0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
